// File: rtl/avalon_edge_capture_ctrl_pkg.sv
// Shared register map, field offsets and elaboration helpers for the
// Avalon edge-capture controller.
package avalon_edge_capture_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_EDGE_EN  = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE  = 2'd3;

    localparam int FALL_EN_LSB = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/avalon_edge_capture_ctrl_debounce_filter.sv
// One-bit debounce filter: the filtered level follows the synchronized input
// only after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
module debounce_filter
    import avalon_edge_capture_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic s_i,
    output logic filt_o,
    output logic update_o
);

    localparam int            CW       = clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          update_s;

    // Any agreement restarts the count, so every bounce costs a full window.
    always_comb begin
        filt_d   = filt_q;
        cnt_d    = cnt_q;
        update_s = 1'b0;
        if (s_i == filt_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            filt_d   = s_i;
            cnt_d    = {CW{1'b0}};
            update_s = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1'b1);
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= 1'b0;
            cnt_q  <= {CW{1'b0}};
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o   = filt_q;
    assign update_o = update_s;

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer cell for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability-settling shift chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/avalon_edge_capture_ctrl.sv
// Avalon-MM slave exposing WIDTH debounced async inputs with per-bit edge
// capture (sticky, write-1-to-clear) and a maskable level interrupt.
module avalon_edge_capture_ctrl
    import avalon_edge_capture_ctrl_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_async,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] filt_s;
    logic [WIDTH-1:0] update_s;
    logic [WIDTH-1:0] set_s;
    logic [31:0]      edge_en_word_s;
    logic             unused_wdata_s;

    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] capture_q, capture_d;
    logic [31:0]      readdata_q, readdata_d;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        sync_2ff u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .d_i     (in_async[gi]),
            .q_o     (sync_s[gi])
        );

        debounce_filter #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset_n  (reset_n),
            .s_i      (sync_s[gi]),
            .filt_o   (filt_s[gi]),
            .update_o (update_s[gi])
        );
    end

    assign unused_wdata_s = ^writedata;

    // Direction of an update is the new level, which equals the synchronized input.
    assign set_s = update_s & ((sync_s & rise_en_q) | (~sync_s & fall_en_q));

    // Packed view of rise and fall enables as software sees them.
    always_comb begin
        edge_en_word_s                       = 32'h0000_0000;
        edge_en_word_s[WIDTH-1:0]            = rise_en_q;
        edge_en_word_s[FALL_EN_LSB +: WIDTH] = fall_en_q;
    end

    // Register file next state; capture sets are OR-ed in after the clear so a set wins.
    always_comb begin
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        irq_mask_d = irq_mask_q;
        capture_d  = capture_q;
        readdata_d = readdata_q;
        if (write) begin
            case (address)
                ADDR_EDGE_EN: begin
                    rise_en_d = writedata[WIDTH-1:0];
                    fall_en_d = writedata[FALL_EN_LSB +: WIDTH];
                end
                ADDR_IRQ_MASK: irq_mask_d = writedata[WIDTH-1:0];
                ADDR_CAPTURE:  capture_d  = capture_q & ~writedata[WIDTH-1:0];
                default:       capture_d  = capture_q;
            endcase
        end else begin
            capture_d = capture_q;
        end
        capture_d = capture_d | set_s;
        if (read) begin
            case (address)
                ADDR_DATA:     readdata_d = {{(32-WIDTH){1'b0}}, filt_s};
                ADDR_EDGE_EN:  readdata_d = edge_en_word_s;
                ADDR_IRQ_MASK: readdata_d = {{(32-WIDTH){1'b0}}, irq_mask_q};
                default:       readdata_d = {{(32-WIDTH){1'b0}}, capture_q};
            endcase
        end else begin
            readdata_d = readdata_q;
        end
    end

    // Register file and read-data state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en_q  <= {WIDTH{1'b0}};
            fall_en_q  <= {WIDTH{1'b0}};
            irq_mask_q <= {WIDTH{1'b0}};
            capture_q  <= {WIDTH{1'b0}};
            readdata_q <= 32'h0000_0000;
        end else begin
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            irq_mask_q <= irq_mask_d;
            capture_q  <= capture_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(capture_q & irq_mask_q);

endmodule

// File: tb/tb_avalon_edge_capture_ctrl.sv
// Scoreboard bench for avalon_edge_capture_ctrl: a behavioural model predicts
// irq every cycle and read data for every read; a monitor compares.
module tb_avalon_edge_capture_ctrl;

    localparam int W  = 8;
    localparam int DB = 4;

    logic        clk;
    logic        reset_n;
    logic [7:0]  in_async;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    avalon_edge_capture_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_async  (in_async),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  m_filt, m_cap, m_rise, m_fall, m_mask;
    logic [7:0]  s_now, upd, set_v;
    logic [7:0]  in_hist[$];
    logic [7:0]  s_hist[$];
    logic        exp_irq;
    logic [31:0] exp_rd_q[$];
    bit          all_diff;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_word(input logic [1:0] a);
        case (a)
            2'd0:    return {24'h0, m_filt};
            2'd1:    return {8'h0, m_fall, 8'h0, m_rise};
            2'd2:    return {24'h0, m_mask};
            default: return {24'h0, m_cap};
        endcase
    endfunction

    task automatic model_clear();
        m_filt = 8'h00; m_cap = 8'h00; m_rise = 8'h00; m_fall = 8'h00; m_mask = 8'h00;
        in_hist.delete();
        s_hist.delete();
        exp_rd_q.delete();
        exp_irq = 1'b0;
    endtask

    // Model: filtered level flips once the synchronized input (input two edges
    // ago) has disagreed with it on DB consecutive edges.
    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_clear();
            end else begin
                in_hist.push_back(in_async);
                if (in_hist.size() > 3) void'(in_hist.pop_front());
                s_now = (in_hist.size() == 3) ? in_hist[0] : 8'h00;
                s_hist.push_back(s_now);
                if (s_hist.size() > DB) void'(s_hist.pop_front());
                upd = 8'h00;
                if (s_hist.size() == DB) begin
                    for (int i = 0; i < W; i++) begin
                        all_diff = 1'b1;
                        foreach (s_hist[j]) if (s_hist[j][i] == m_filt[i]) all_diff = 1'b0;
                        upd[i] = all_diff;
                    end
                end
                set_v = upd & ((s_now & m_rise) | (~s_now & m_fall));
                if (read) exp_rd_q.push_back(reg_word(address));
                if (write) begin
                    case (address)
                        2'd1: begin m_rise = writedata[7:0]; m_fall = writedata[23:16]; end
                        2'd2: m_mask = writedata[7:0];
                        2'd3: m_cap = m_cap & ~writedata[7:0];
                        default: ;
                    endcase
                end
                m_cap   = m_cap | set_v;
                m_filt  = m_filt ^ upd;
                exp_irq = |(m_cap & m_mask);
            end
        end
    end

    // Monitor: compares on the falling edge, away from DUT updates.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("reset_irq", {31'd0, irq}, 32'd0);
                check("reset_readdata", readdata, 32'd0);
            end else begin
                check("irq", {31'd0, irq}, {31'd0, exp_irq});
                if (exp_rd_q.size() > 0) check("readdata", readdata, exp_rd_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick(1);
        write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a; read = 1'b1;
        tick(1);
        read = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1; in_async = 8'h00; address = 2'd0;
        read = 1'b0; write = 1'b0; writedata = 32'h0;
        #1 reset_n = 1'b0;
        in_async = 8'($urandom);
        tick(5);
        in_async = 8'h00;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin rd(2'd0); rd(2'd3); end

        // Latency: rise on bit 0 captured and interrupting six edges after the step
        wr(2'd1, 32'h0000_0001);
        wr(2'd2, 32'h0000_0001);
        in_async[0] = 1'b1;
        tick(8);
        check("latency_irq", {31'd0, irq}, 32'd1);
        rd(2'd3);
        rd(2'd0);

        // Glitch then bounce on bit 1
        wr(2'd3, 32'h0000_00FF);
        wr(2'd1, 32'h0000_0002);
        wr(2'd2, 32'h0000_0002);
        in_async[1] = 1'b1; tick(2);
        in_async[1] = 1'b0; tick(8);
        check("glitch_irq", {31'd0, irq}, 32'd0);
        rd(2'd0); rd(2'd3);
        in_async[1] = 1'b1; tick(1);
        in_async[1] = 1'b0; tick(1);
        in_async[1] = 1'b1; tick(8);
        check("bounce_irq", {31'd0, irq}, 32'd1);
        rd(2'd3);

        // Fall capture with mask closed, then open, then clear
        wr(2'd3, 32'h0000_00FF);
        wr(2'd1, 32'h0004_0000);
        wr(2'd2, 32'h0000_0000);
        in_async[2] = 1'b1; tick(8);
        in_async[2] = 1'b0; tick(8);
        rd(2'd3);
        check("fall_masked_irq", {31'd0, irq}, 32'd0);
        wr(2'd2, 32'h0000_0004);
        check("fall_unmask_irq", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'h0000_0004);
        check("fall_clear_irq", {31'd0, irq}, 32'd0);
        rd(2'd3);

        // Set/clear collision on bit 0
        wr(2'd1, 32'h0000_0001);
        wr(2'd2, 32'h0000_0001);
        wr(2'd3, 32'h0000_00FF);
        in_async[0] = 1'b0; tick(8);
        in_async[0] = 1'b1; tick(5);
        wr(2'd3, 32'h0000_0001);
        check("collision_irq", {31'd0, irq}, 32'd1);
        rd(2'd3);

        // Reset while bit 0 is mid-debounce
        wr(2'd3, 32'h0000_00FF);
        in_async[0] = 1'b0; tick(8);
        in_async[0] = 1'b1; tick(4);
        reset_n = 1'b0;
        #1;
        check("midrst_readdata", readdata, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        wr(2'd1, 32'h0000_0001);
        wr(2'd2, 32'h0000_0001);
        tick(10);
        rd(2'd3);
        rd(2'd0);

        // Randomized traffic with bouncing inputs
        for (int n = 0; n < 1500; n++) begin
            int r;
            for (int b = 0; b < W; b++) if ($urandom_range(0, 7) == 0) in_async[b] = ~in_async[b];
            r         = int'($urandom_range(0, 9));
            read      = (r < 4);
            write     = (r >= 7);
            address   = 2'($urandom_range(0, 3));
            writedata = $urandom;
            tick(1);
        end
        read = 1'b0; write = 1'b0;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
